router_port_fifo: RTL and testbench

Packet-aware output buffer for one router output port; four instances sit between the switch core and the `ready_N`/`read_N`/`data_N` port pins that the bench monitor drains. It accepts bytes from the core with an end-of-packet marker and makes a packet visible to the reader only once it is completely stored. It exposes the ready/read/data handshake one packet at a time. A packet that cannot fit is dropped whole, never truncated.

---
 rtl/router_port_fifo.sv | 183 ++++++++++++++++++
 tb/tb_router_port_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_fifo.sv
// -----------------------------------------------------------------------------
// router_port_fifo
//
// Packet-aware output buffer for one router output port. Bytes arrive from the
// switch core with an end-of-packet marker. A packet becomes visible to the
// reader only once its last byte is stored. A packet that cannot fit is
// discarded whole, never truncated.
//
// Ports:
//   clock         in   rising-edge clock
//   reset         in   asynchronous, active-low reset
//   wr_valid      in   write byte strobe from the switch core
//   wr_data[7:0]  in   byte written when wr_valid=1
//   wr_last       in   final byte of the packet (qualified by wr_valid)
//   ready         out  a complete packet is being presented to the reader
//   read          in   reader pops one byte while ready=1
//   data[7:0]     out  registered read data
//   drop          out  one-cycle pulse when an in-progress packet is discarded
//   pkt_count     out  number of complete packets stored (AW+1 bits)
//   wr_state_dbg  out  write FSM state (0 ACCEPT, 1 DISCARD)
//   rd_state_dbg  out  read FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Read handshake: a byte transfers on every rising edge where ready=1 and
// read=1; data carries that byte after the edge. read while ready=0 is
// ignored, and read=0 while ready=1 holds both data and the read pointer.
// -----------------------------------------------------------------------------
module router_port_fifo #(
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_valid,
   input  logic [7:0]    wr_data,
   input  logic          wr_last,
   output logic          ready,
   input  logic          read,
   output logic [7:0]    data,
   output logic          drop,
   output logic [AW:0]   pkt_count,
   output logic          wr_state_dbg,
   output logic [1:0]    rd_state_dbg
);

   localparam logic [0:0] WR_ACCEPT  = 1'b0;
   localparam logic [0:0] WR_DISCARD = 1'b1;

   localparam logic [1:0] RD_IDLE = 2'd0;
   localparam logic [1:0] RD_SEND = 2'd1;
   localparam logic [1:0] RD_GAP  = 2'd2;

   localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

   // Each entry holds {last, byte}.
   logic [8:0]    mem [DEPTH];

   logic [AW:0]   wp;      // speculative write pointer
   logic [AW:0]   wp_c;    // committed write pointer
   logic [AW:0]   rp;      // read pointer

   logic [0:0]    wr_state;
   logic [1:0]    rd_state;

   logic [AW:0]   occupancy;
   logic          full;
   logic          wr_accept;
   logic          wr_overflow;
   logic          commit;
   logic          pop;
   logic          pop_last;
   logic [8:0]    rd_entry;

   // Full uses the pre-edge pointers, so a pop in the same cycle never makes
   // room for that cycle's write. Occupancy counts speculative bytes too.
   always_comb begin
      occupancy   = wp - rp;
      full        = (occupancy == FULL_LEVEL);
      wr_accept   = (wr_state == WR_ACCEPT) && wr_valid && !full;
      wr_overflow = (wr_state == WR_ACCEPT) && wr_valid && full;
      commit      = wr_accept && wr_last;
      rd_entry    = mem[rp[AW-1:0]];
      pop         = (rd_state == RD_SEND) && read;
      pop_last    = pop && rd_entry[8];
   end

   assign ready        = (rd_state == RD_SEND);
   assign wr_state_dbg = wr_state[0];
   assign rd_state_dbg = rd_state;

   // Storage array is not reset; the pointers alone define valid contents.
   always_ff @(posedge clock) begin
      if (wr_accept) begin
         mem[wp[AW-1:0]] <= {wr_last, wr_data};
      end
   end

   // Write side: speculative fill, commit on last byte, rewind on overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_state <= WR_ACCEPT;
         wp       <= '0;
         wp_c     <= '0;
         drop     <= 1'b0;
      end else begin
         drop <= 1'b0;
         case (wr_state)
            WR_ACCEPT: begin
               if (wr_accept) begin
                  wp <= wp + PTR_ONE;
                  if (wr_last) begin
                     wp_c <= wp + PTR_ONE;
                  end
               end else if (wr_overflow) begin
                  // Throw away the partial packet. A full FIFO on the last
                  // byte ends the packet here; otherwise swallow the rest.
                  wp   <= wp_c;
                  drop <= 1'b1;
                  if (!wr_last) begin
                     wr_state <= WR_DISCARD;
                  end
               end
            end
            WR_DISCARD: begin
               if (wr_valid && wr_last) begin
                  wr_state <= WR_ACCEPT;
               end
            end
            default: wr_state <= WR_ACCEPT;
         endcase
      end
   end

   // Read side: present one packet at a time with a one-cycle gap after it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_state <= RD_IDLE;
         rp       <= '0;
         data     <= 8'h00;
      end else begin
         case (rd_state)
            RD_IDLE: begin
               if (pkt_count != '0) begin
                  rd_state <= RD_SEND;
               end
            end
            RD_SEND: begin
               if (pop) begin
                  data <= rd_entry[7:0];
                  rp   <= rp + PTR_ONE;
                  if (rd_entry[8]) begin
                     rd_state <= RD_GAP;
                  end
               end
            end
            RD_GAP: begin
               // A queued packet is presented straight after the single gap
               // cycle, so ready is low for exactly one cycle between packets.
               if (pkt_count != '0) begin
                  rd_state <= RD_SEND;
               end else begin
                  rd_state <= RD_IDLE;
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   // Commit and final pop in the same cycle cancel out.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pkt_count <= '0;
      end else begin
         case ({commit, pop_last})
            2'b10:   pkt_count <= pkt_count + PTR_ONE;
            2'b01:   pkt_count <= pkt_count - PTR_ONE;
            default: pkt_count <= pkt_count;
         endcase
      end
   end

endmodule

// File: tb/tb_router_port_fifo.sv
// -----------------------------------------------------------------------------
// tb_router_port_fifo
//
// Directed bench for router_port_fifo (DEPTH=64). Inputs change 1 ns after
// the rising edge; outputs are checked at the same point, i.e. they reflect
// the most recent edge.
// -----------------------------------------------------------------------------
module tb_router_port_fifo;

   logic         clock;
   logic         reset;
   logic         wr_valid;
   logic [7:0]   wr_data;
   logic         wr_last;
   logic         ready;
   logic         read;
   logic [7:0]   data;
   logic         drop;
   logic [6:0]   pkt_count;
   logic         wr_state_dbg;
   logic [1:0]   rd_state_dbg;

   int checks   = 0;
   int failures = 0;

   router_port_fifo #(.DEPTH(64)) dut (
      .clock        (clock),
      .reset        (reset),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_last      (wr_last),
      .ready        (ready),
      .read         (read),
      .data         (data),
      .drop         (drop),
      .pkt_count    (pkt_count),
      .wr_state_dbg (wr_state_dbg),
      .rd_state_dbg (rd_state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic put(input logic [7:0] d, input logic l);
      wr_valid = 1'b1;
      wr_data  = d;
      wr_last  = l;
      tick();
      wr_valid = 1'b0;
      wr_last  = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; wr_last = 1'b0; read = 1'b0;
      tick(); tick();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", ready); end
      checks++; if (data !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", data); end
      checks++; if (drop !== 1'b0) begin failures++; $display("FAIL rst_drop: got %b want 0", drop); end
      checks++; if (pkt_count !== 7'd0) begin failures++; $display("FAIL rst_pkt_count: got %0d want 0", pkt_count); end
      checks++; if (wr_state_dbg !== 1'b0 || rd_state_dbg !== 2'd0) begin failures++; $display("FAIL rst_states: got %b/%0d want 0/0", wr_state_dbg, rd_state_dbg); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic_packet();
      logic [7:0] exp_d [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      for (int i = 0; i < 5; i++) put(exp_d[i], i == 4);
      checks++; if (pkt_count !== 7'd1) begin failures++; $display("FAIL basic_commit: pkt_count got %0d want 1", pkt_count); end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_early: got %b want 0", ready); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL basic_ready: got %b want 1", ready); end
      read = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (data !== exp_d[i]) begin failures++; $display("FAIL basic_data[%0d]: got %h want %h", i, data, exp_d[i]); end
         if (i == 1) begin
            // stall for one cycle mid-packet
            read = 1'b0;
            tick();
            checks++; if (data !== 8'h22 || ready !== 1'b1) begin failures++; $display("FAIL basic_stall: data %h ready %b want 22/1", data, ready); end
            read = 1'b1;
         end
      end
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL basic_ready_end: got %b want 0", ready); end
      checks++; if (pkt_count !== 7'd0) begin failures++; $display("FAIL basic_pkt_end: got %0d want 0", pkt_count); end
      read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [7] = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h04, 8'h05, 8'h06};
      logic       exp_r [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) put(8'(i + 1), (i == 2) || (i == 5));
      checks++; if (pkt_count !== 7'd2 || ready !== 1'b1) begin failures++; $display("FAIL b2b_setup: pkt %0d ready %b want 2/1", pkt_count, ready); end
      read = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         checks++; if (data !== exp_d[i] || ready !== exp_r[i]) begin failures++; $display("FAIL b2b_cycle[%0d]: data %h ready %b want %h/%b", i, data, ready, exp_d[i], exp_r[i]); end
      end
      checks++; if (pkt_count !== 7'd0) begin failures++; $display("FAIL b2b_pkt_end: got %0d want 0", pkt_count); end
      read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 60; i++) put(8'(i + 1), i == 59);
      checks++; if (pkt_count !== 7'd1) begin failures++; $display("FAIL ovf_first: pkt_count got %0d want 1", pkt_count); end
      for (int i = 0; i < 10; i++) begin
         put(8'(8'hA0 + i), i == 9);
         checks++; if (drop !== (i == 4)) begin failures++; $display("FAIL ovf_drop[%0d]: got %b want %b", i, drop, (i == 4)); end
         if (i == 4) begin
            checks++; if (wr_state_dbg !== 1'b1) begin failures++; $display("FAIL ovf_discard_state: got %b want 1", wr_state_dbg); end
         end
      end
      checks++; if (pkt_count !== 7'd1 || ready !== 1'b1) begin failures++; $display("FAIL ovf_after: pkt %0d ready %b want 1/1", pkt_count, ready); end
      checks++; if (wr_state_dbg !== 1'b0) begin failures++; $display("FAIL ovf_back_accept: got %b want 0", wr_state_dbg); end
      read = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         checks++; if (data !== 8'(i + 1)) begin failures++; $display("FAIL ovf_data[%0d]: got %h want %h", i, data, 8'(i + 1)); end
      end
      checks++; if (ready !== 1'b0 || pkt_count !== 7'd0) begin failures++; $display("FAIL ovf_end: ready %b pkt %0d want 0/0", ready, pkt_count); end
      read = 1'b0;
      tick(); tick(); tick();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ovf_no_ghost: ready got %b want 0", ready); end
   endtask

   task automatic test_long_drop();
      for (int i = 0; i < 70; i++) begin
         put(8'(8'h80 + i), i == 69);
         checks++; if (drop !== (i == 64) || ready !== 1'b0) begin failures++; $display("FAIL long_byte[%0d]: drop %b ready %b want %b/0", i, drop, ready, (i == 64)); end
      end
      checks++; if (pkt_count !== 7'd0) begin failures++; $display("FAIL long_pkt: got %0d want 0", pkt_count); end
      tick(); tick();
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL long_ready: got %b want 0", ready); end
      put(8'h5A, 1'b0);
      put(8'hA5, 1'b1);
      checks++; if (pkt_count !== 7'd1) begin failures++; $display("FAIL long_next_pkt: got %0d want 1", pkt_count); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL long_next_ready: got %b want 1", ready); end
      read = 1'b1;
      tick();
      checks++; if (data !== 8'h5A) begin failures++; $display("FAIL long_next_d0: got %h want 5a", data); end
      tick();
      checks++; if (data !== 8'hA5 || ready !== 1'b0) begin failures++; $display("FAIL long_next_d1: data %h ready %b want a5/0", data, ready); end
      read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_commit_pop();
      put(8'h31, 1'b0);
      put(8'h32, 1'b1);
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL cp_ready: got %b want 1", ready); end
      read = 1'b1;
      tick();
      checks++; if (data !== 8'h31) begin failures++; $display("FAIL cp_d0: got %h want 31", data); end
      // final pop and a 1-byte commit on the same edge
      wr_valid = 1'b1; wr_data = 8'h77; wr_last = 1'b1;
      tick();
      wr_valid = 1'b0; wr_last = 1'b0; read = 1'b0;
      checks++; if (data !== 8'h32 || ready !== 1'b0) begin failures++; $display("FAIL cp_d1: data %h ready %b want 32/0", data, ready); end
      checks++; if (pkt_count !== 7'd1) begin failures++; $display("FAIL cp_pkt_same: got %0d want 1", pkt_count); end
      tick();
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL cp_after_gap: ready got %b want 1", ready); end
      read = 1'b1;
      tick();
      checks++; if (data !== 8'h77 || ready !== 1'b0 || pkt_count !== 7'd0) begin failures++; $display("FAIL cp_single: data %h ready %b pkt %0d want 77/0/0", data, ready, pkt_count); end
      read = 1'b0;
      tick(); tick();
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp_d [3] = '{8'h44, 8'h55, 8'h66};
      for (int i = 0; i < 4; i++) put(8'(8'h10 + i), i == 3);
      tick();
      read = 1'b1;
      tick();
      wr_valid = 1'b1; wr_data = 8'h20; wr_last = 1'b0;
      tick();
      checks++; if (data !== 8'h11 || ready !== 1'b1) begin failures++; $display("FAIL rm_pre: data %h ready %b want 11/1", data, ready); end
      // assert reset between edges while writing and reading
      reset = 1'b0;
      #1;
      checks++; if (ready !== 1'b0 || data !== 8'h00 || drop !== 1'b0 || pkt_count !== 7'd0) begin failures++; $display("FAIL rm_async: ready %b data %h drop %b pkt %0d want 0/00/0/0", ready, data, drop, pkt_count); end
      wr_valid = 1'b0; read = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) put(exp_d[i], i == 2);
      checks++; if (pkt_count !== 7'd1) begin failures++; $display("FAIL rm_pkt: got %0d want 1", pkt_count); end
      tick();
      read = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (data !== exp_d[i]) begin failures++; $display("FAIL rm_data[%0d]: got %h want %h", i, data, exp_d[i]); end
      end
      checks++; if (ready !== 1'b0 || pkt_count !== 7'd0) begin failures++; $display("FAIL rm_end: ready %b pkt %0d want 0/0", ready, pkt_count); end
      read = 1'b0;
      tick(); tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_packet();
      test_back_to_back();
      test_overflow();
      test_long_drop();
      test_commit_pop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
